// File: rtl/store_buffer_pkg.sv
// Shared processor constants and the store-buffer entry layout.
package store_buffer_pkg;

    localparam int SB_DEPTH = 4;
    localparam int SB_AW    = 32;
    localparam int SB_DW    = 32;

    typedef struct packed {
        logic             valid;
        logic [SB_AW-1:0] addr;
        logic [SB_DW-1:0] data;
    } sb_entry_t;

endpackage

// File: rtl/store_buffer_match.sv
// sb_match: parallel address compare over all entries and youngest-match select,
// walking from the head (oldest) so the last hit found is the youngest.
module sb_match
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    parameter int AW    = SB_AW,
    localparam int IW   = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0]         valid,
    input  logic [DEPTH-1:0][AW-1:0] addr,
    input  logic [IW-1:0]            head,
    input  logic [AW-1:0]            key,
    output logic                     hit,
    output logic [IW-1:0]            idx
);

    logic [DEPTH-1:0] match_s;
    logic [IW-1:0]    slot_s;

    for (genvar i = 0; i < DEPTH; i++) begin : g_cmp
        assign match_s[i] = valid[i] & (addr[i] == key);
    end

    // age-ordered priority select
    always_comb begin
        hit    = |match_s;
        idx    = head;
        slot_s = head;
        for (int k = 0; k < DEPTH; k++) begin
            slot_s = head + IW'(k);
            idx    = match_s[slot_s] ? slot_s : idx;
        end
    end

endmodule

// File: rtl/store_buffer.sv
// Store buffer: circular FIFO of pending stores with youngest-entry merge,
// load forwarding, opportunistic drain to the data cache and flush.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    parameter int AW    = SB_AW,
    parameter int DW    = SB_DW,
    localparam int IW   = $clog2(DEPTH),
    localparam int PW   = IW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          st_valid,
    input  logic [AW-1:0] st_addr,
    input  logic [DW-1:0] st_data,
    output logic          st_ready,
    input  logic          ld_valid,
    input  logic [AW-1:0] ld_addr,
    output logic          ld_hit,
    output logic [DW-1:0] ld_data,
    input  logic          mem_idle,
    input  logic          flush,
    output logic          dc_wr_valid,
    output logic [AW-1:0] dc_wr_addr,
    output logic [DW-1:0] dc_wr_data,
    input  logic          dc_wr_ready,
    output logic          full,
    output logic          empty,
    output logic [PW-1:0] count
);

    logic [PW-1:0]              head_r;
    logic [PW-1:0]              tail_r;
    logic [DEPTH-1:0]           valid_r;
    logic [DEPTH-1:0][AW-1:0]   addr_r;
    logic [DEPTH-1:0][DW-1:0]   data_r;
    logic                       flush_active_r;

    logic [IW-1:0] head_idx_s;
    logic [IW-1:0] tail_idx_s;
    logic [IW-1:0] young_idx_s;
    logic          full_s;
    logic          empty_s;
    logic          st_fire_s;
    logic          merge_s;
    logic          enq_s;
    logic          retire_s;
    logic [PW-1:0] head_nxt_s;
    logic [PW-1:0] tail_nxt_s;
    logic          flush_nxt_s;
    logic          match_hit_s;
    logic [IW-1:0] match_idx_s;

    assign head_idx_s  = head_r[IW-1:0];
    assign tail_idx_s  = tail_r[IW-1:0];
    assign young_idx_s = tail_idx_s - IW'(1);

    assign empty_s = (head_r == tail_r);
    assign full_s  = (head_idx_s == tail_idx_s) & (head_r[PW-1] != tail_r[PW-1]);

    assign st_ready    = ~full_s & ~flush_active_r;
    assign dc_wr_valid = ~empty_s & (mem_idle | full_s | flush_active_r);
    assign dc_wr_addr  = addr_r[head_idx_s];
    assign dc_wr_data  = data_r[head_idx_s];
    assign full        = full_s;
    assign empty       = empty_s;
    assign count       = tail_r - head_r;

    assign retire_s  = dc_wr_valid & dc_wr_ready;
    assign st_fire_s = st_valid & st_ready;
    // The head entry is never merged while it is offered, keeping the cache port stable.
    assign merge_s   = st_fire_s & valid_r[young_idx_s] & (addr_r[young_idx_s] == st_addr)
                     & ~(dc_wr_valid & (young_idx_s == head_idx_s));
    assign enq_s     = st_fire_s & ~merge_s;

    // next pointers and flush state
    always_comb begin
        head_nxt_s  = head_r;
        tail_nxt_s  = tail_r;
        flush_nxt_s = flush_active_r;
        if (retire_s) begin
            head_nxt_s = head_r + PW'(1);
        end else begin
            head_nxt_s = head_r;
        end
        if (enq_s) begin
            tail_nxt_s = tail_r + PW'(1);
        end else begin
            tail_nxt_s = tail_r;
        end
        if (head_nxt_s == tail_nxt_s) begin
            flush_nxt_s = 1'b0;
        end else begin
            flush_nxt_s = flush_active_r | (flush & ~empty_s);
        end
    end

    // pointer, valid-bit and flush registers
    always_ff @(posedge clk) begin
        if (reset) begin
            head_r         <= {PW{1'b0}};
            tail_r         <= {PW{1'b0}};
            valid_r        <= {DEPTH{1'b0}};
            flush_active_r <= 1'b0;
        end else begin
            head_r         <= head_nxt_s;
            tail_r         <= tail_nxt_s;
            flush_active_r <= flush_nxt_s;
            if (enq_s) begin
                valid_r[tail_idx_s] <= 1'b1;
            end
            if (retire_s) begin
                valid_r[head_idx_s] <= 1'b0;
            end
        end
    end

    // entry payload; contents are only observed through valid bits
    always_ff @(posedge clk) begin
        if (!reset && enq_s) begin
            addr_r[tail_idx_s] <= st_addr;
            data_r[tail_idx_s] <= st_data;
        end else if (!reset && merge_s) begin
            data_r[young_idx_s] <= st_data;
        end
    end

    sb_match #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_match (
        .valid (valid_r),
        .addr  (addr_r),
        .head  (head_idx_s),
        .key   (ld_addr),
        .hit   (match_hit_s),
        .idx   (match_idx_s)
    );

    assign ld_hit  = ld_valid & match_hit_s;
    assign ld_data = ld_hit ? data_r[match_idx_s] : {DW{1'b0}};

endmodule

// File: tb/tb_store_buffer.sv
// Directed self-checking bench for store_buffer (DEPTH=4, 32-bit addr/data).
module tb_store_buffer;

    logic        clk = 1'b0;
    logic        reset, st_valid, st_ready, ld_valid, ld_hit;
    logic        mem_idle, flush, dc_wr_valid, dc_wr_ready, full, empty;
    logic [31:0] st_addr, st_data, ld_addr, ld_data, dc_wr_addr, dc_wr_data;
    logic [2:0]  count;

    int checks = 0;
    int failures = 0;
    logic [31:0] qa[$];
    logic [31:0] qd[$];
    int n;

    always #5 clk = ~clk;

    store_buffer dut (
        .clk(clk), .reset(reset),
        .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_ready(st_ready),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_hit(ld_hit), .ld_data(ld_data),
        .mem_idle(mem_idle), .flush(flush),
        .dc_wr_valid(dc_wr_valid), .dc_wr_addr(dc_wr_addr), .dc_wr_data(dc_wr_data),
        .dc_wr_ready(dc_wr_ready),
        .full(full), .empty(empty), .count(count)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        st_valid = 1'b1;
        st_addr  = a;
        st_data  = d;
        tick();
        st_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; st_valid = 1'b0; st_addr = 32'h0; st_data = 32'h0;
        ld_valid = 1'b0; ld_addr = 32'h0; mem_idle = 1'b0; flush = 1'b0; dc_wr_ready = 1'b0;
        tick(); tick();
        reset = 1'b0;
        #1;
        check("rst_empty", empty, 1); check("rst_full", full, 0); check("rst_count", count, 0);
        check("rst_st_ready", st_ready, 1); check("rst_dc_valid", dc_wr_valid, 0);
        ld_valid = 1'b1; ld_addr = 32'h10; #1;
        check("rst_ld_hit", ld_hit, 0); check("rst_ld_data", ld_data, 0);
        ld_valid = 1'b0;

        // fill to full with the cache busy: full alone forces the drain request
        store(32'h10, 32'hA); store(32'h14, 32'hB); store(32'h18, 32'hC); store(32'h1C, 32'hD);
        #1;
        check("fill_full", full, 1); check("fill_st_ready", st_ready, 0);
        check("fill_count", count, 4); check("fill_dc_valid", dc_wr_valid, 1);
        check("fill_dc_addr", dc_wr_addr, 32'h10); check("fill_dc_data", dc_wr_data, 32'hA);
        tick();
        check("stall_dc_addr", dc_wr_addr, 32'h10); check("stall_dc_data", dc_wr_data, 32'hA);
        qa = {32'h10, 32'h14, 32'h18, 32'h1C};
        qd = {32'hA, 32'hB, 32'hC, 32'hD};

        // full: retire one, refill one, alternating; pointers wrap
        dc_wr_ready = 1'b1;
        n = 0;
        for (int r = 0; r < 6; r++) begin
            st_valid = 1'b1; st_addr = 32'h40 + 32'(4 * n); st_data = 32'h100 + 32'(n);
            #1;
            check("alt_st_ready_full", st_ready, 0); check("alt_dc_valid", dc_wr_valid, 1);
            check("alt_dc_addr", dc_wr_addr, qa[0]); check("alt_dc_data", dc_wr_data, qd[0]);
            void'(qa.pop_front()); void'(qd.pop_front());
            tick();
            check("alt_st_ready_after", st_ready, 1); check("alt_count", count, 3);
            check("alt_dc_idle", dc_wr_valid, 0);
            qa.push_back(st_addr); qd.push_back(st_data);
            n++;
            tick();
        end
        st_valid = 1'b0; mem_idle = 1'b1;
        for (int r = 0; r < 4; r++) begin
            #1;
            check("drain_valid", dc_wr_valid, 1);
            check("drain_addr", dc_wr_addr, qa[0]); check("drain_data", dc_wr_data, qd[0]);
            void'(qa.pop_front()); void'(qd.pop_front());
            tick();
        end
        check("drain_empty", empty, 1); check("drain_count", count, 0); check("drain_dc_valid", dc_wr_valid, 0);

        // merge into youngest; same-cycle store not forwarded
        mem_idle = 1'b0; dc_wr_ready = 1'b0;
        st_valid = 1'b1; st_addr = 32'h20; st_data = 32'h1; ld_valid = 1'b1; ld_addr = 32'h20; #1;
        check("fwd_same_cycle_excluded", ld_hit, 0);
        tick();
        st_data = 32'h2; #1;
        check("fwd_pre_merge_data", ld_data, 32'h1);
        tick();
        st_valid = 1'b0; #1;
        check("merge_count", count, 1); check("merge_ld_hit", ld_hit, 1); check("merge_ld_data", ld_data, 32'h2);
        ld_addr = 32'h24; #1;
        check("miss_ld_hit", ld_hit, 0); check("miss_ld_data", ld_data, 0);
        ld_addr = 32'h20; mem_idle = 1'b1; dc_wr_ready = 1'b1; #1;
        check("idle_dc_valid", dc_wr_valid, 1); check("idle_dc_data", dc_wr_data, 32'h2);
        check("fwd_retiring_included", ld_hit, 1);
        tick();
        check("post_retire_empty", empty, 1); check("post_retire_ld_hit", ld_hit, 0);

        // non-adjacent duplicates: youngest match wins
        mem_idle = 1'b0; dc_wr_ready = 1'b0;
        store(32'h30, 32'h5); store(32'h34, 32'h6); store(32'h30, 32'h7);
        #1;
        check("dup_count", count, 3);
        ld_addr = 32'h30; #1; check("dup_ld_youngest", ld_data, 32'h7);
        ld_addr = 32'h34; #1; check("dup_ld_mid", ld_data, 32'h6);
        ld_valid = 1'b0; #1; check("ld_valid_gate", ld_hit, 0);

        // flush drains all three with the cache otherwise busy
        dc_wr_ready = 1'b1; flush = 1'b1; #1;
        check("flush_pulse_dc_valid", dc_wr_valid, 0);
        tick();
        flush = 1'b0; st_valid = 1'b1; st_addr = 32'h50; st_data = 32'h55;
        qa = {32'h30, 32'h34, 32'h30};
        qd = {32'h5, 32'h6, 32'h7};
        for (int r = 0; r < 3; r++) begin
            #1;
            check("flush_dc_valid", dc_wr_valid, 1); check("flush_st_ready", st_ready, 0);
            check("flush_dc_addr", dc_wr_addr, qa[r]); check("flush_dc_data", dc_wr_data, qd[r]);
            tick();
        end
        st_valid = 1'b0; #1;
        check("flush_done_empty", empty, 1); check("flush_done_count", count, 0);
        check("flush_done_st_ready", st_ready, 1); check("flush_done_dc_valid", dc_wr_valid, 0);
        flush = 1'b1; tick(); flush = 1'b0; #1;
        check("flush_empty_noop", st_ready, 1);

        // reset discards pending stores
        mem_idle = 1'b1; dc_wr_ready = 1'b0;
        store(32'h60, 32'h11); store(32'h64, 32'h22);
        #1;
        check("pre_rst_count", count, 2); check("pre_rst_dc_valid", dc_wr_valid, 1);
        reset = 1'b1; tick(); reset = 1'b0;
        ld_valid = 1'b1; ld_addr = 32'h60; #1;
        check("rst2_empty", empty, 1); check("rst2_count", count, 0);
        check("rst2_dc_valid", dc_wr_valid, 0);
        check("rst2_ld_hit", ld_hit, 0); check("rst2_ld_data", ld_data, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
